spi_master: RTL and testbench
=============================

// Module: spi_master
// PURPOSE
//  SPI mode-0 initiator (CPOL=0, CPHA=0), MSB first, one byte per transfer.
//  Drives SCK/MOSI/SSEL toward the FPGA-side SPI_slave. Captures MISO in parallel.
//  Sits between a byte-stream client (valid/ready) and the SPI pins.
//  Serves as the bench driver for the slave and as the link to external SPI peripherals.
// PARAMETERS
//  HALF_DIV  8  clk cycles per SCK half-period. Legal range is 4..255; the 3-flop slave synchronisers need >=4.
//  GAP_DIV   16 clk cycles SSEL is held high between frames (>=4)
// PORTS
//  clk       in   1  system clock, all logic on posedge
//  rst       in   1  asynchronous, active-high reset
//  tx_valid  in   1  client has a byte to send
//  tx_data   in   8  byte to send, sampled when tx_valid&&tx_ready
//  tx_last   in   1  byte ends the frame (SPI_BURST_EN only; ignored otherwise)
//  tx_ready  out  1  master can accept a byte this cycle
//  rx_valid  out  1  one-cycle pulse, rx_data holds the byte shifted in from MISO
//  rx_data   out  8  received byte, stable until the next rx_valid
//  busy      out  1  high whenever state!=IDLE
//  SCK       out  1  SPI clock, idle low
//  MOSI      out  1  master->slave data
//  MISO      in   1  slave->master data; synchronised through 2 flops internally
//  SSEL      out  1  active-low slave select, idle high
// BEHAVIOUR
//  Reset values: SCK=0, SSEL=1, MOSI=0, tx_ready=1, rx_valid=0, rx_data=0, busy=0.
//  Reset in mid-frame aborts immediately and returns to these values. No rx_valid is issued.
//  One divider counter (8b) is reloaded with HALF_DIV-1 on each state entry. Phases end when it reaches 0.
//  A 3b bit counter tracks the bits; tx_shift and rx_shift are 8b registers.
//  States:
//   IDLE : tx_ready=1. On tx_valid, load tx_shift=tx_data and latch tx_last, then go to LEAD.
//   LEAD : SSEL=0, MOSI=tx_shift[7], SCK=0 for HALF_DIV cycles, then go to HIGH with bitcnt=7.
//   HIGH : SCK=1 for HALF_DIV cycles. On the last cycle, rx_shift<={rx_shift[6:0],MISO_sync}.
//          If bitcnt==0, go to TAIL. Otherwise bitcnt-- and go to LOW.
//   LOW  : SCK=0. On entry, tx_shift<<=1 so MOSI=next bit. Lasts HALF_DIV cycles, then go to HIGH.
//   TAIL : SCK=0, SSEL=0 for HALF_DIV cycles. At exit, rx_data<=rx_shift and rx_valid=1 for 1 cycle.
//          Then go to GAP, or to WAIT under burst when latched tx_last=0.
//   GAP  : SSEL=1, SCK=0, MOSI=0 for GAP_DIV cycles, then go to IDLE.
//  MOSI changes only while SCK is low. MISO is sampled just before the SCK falling edge.
//  tx_ready is high only in IDLE (and in WAIT). A tx_valid that arrives while busy waits with no loss.
//  Frame length: HALF_DIV*(1+16) cycles with SSEL low. The minimum byte period is that plus GAP_DIV plus 1 cycle.
//  When rx_valid and a new tx accept fall in the same cycle, both take effect.
// CONFIGURATION
//  SPI_BURST_EN defined: after TAIL with tx_last=0, go to WAIT, where SSEL=0, SCK=0 and tx_ready=1.
//   - WAIT has no timeout.
//   - On tx_valid, load the byte and go to LOW-equivalent setup: MOSI=bit7 for HALF_DIV cycles, then HIGH.
//   - SSEL stays low across the bytes, so the slave echo is seen in the next byte.
//  SPI_BURST_EN undefined: tx_last is ignored and every byte is its own SSEL frame. The WAIT state is absent.
// TESTING
//  - Single byte 0xA5 into an echo slave: SCK shows exactly 8 rising edges. MOSI bits are 1,0,1,0,0,1,0,1.
//    rx_data is 0x00 and rx_valid pulses once. The SSEL low time is 17*HALF_DIV cycles.
//  - MISO forced to 1 throughout -> rx_data=0xFF.
//  - MISO driven 0x3C by the model on falling edges -> rx_data=0x3C.
//  - Back-to-back tx_valid held high with 0x01 then 0x02: the second byte starts only after GAP_DIV cycles
//    of SSEL high. tx_ready is low the whole time between.
//  - BURST_EN: send 0xA5 (tx_last=0) then 0x3C (tx_last=1) to the echo slave. rx sequence is 0x00 then 0xA5.
//    SSEL stays low throughout and goes high only after the second TAIL.
//  - Assert rst at bit 4 of a frame: SSEL=1 and SCK=0 in the same cycle, with no rx_valid.
//    A following byte 0x81 transfers correctly.

Source files
------------

// File: rtl/spi_master.sv
// SPI mode-0 initiator: MSB first, one byte per transfer, valid/ready client side.
// Define SPI_BURST_EN to keep SSEL low across bytes until a byte marked tx_last.
`timescale 1ns/1ps
module spi_master #(
  parameter int unsigned HALF_DIV = 8,
  parameter int unsigned GAP_DIV  = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  input  logic       tx_last,
  output logic       tx_ready,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  output logic       busy,
  output logic       SCK,
  output logic       MOSI,
  input  logic       MISO,
  output logic       SSEL
);

  typedef enum logic [2:0] {
    StIdle,
    StLead,
    StHigh,
    StLow,
    StTail,
    StGap
`ifdef SPI_BURST_EN
    , StWait
`endif
  } state_e;

  localparam logic [7:0] HalfLoad = 8'(HALF_DIV - 1);
  localparam logic [7:0] GapLoad  = 8'(GAP_DIV - 1);

  state_e     state_q, state_d;
  logic [7:0] div_q, div_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] tx_shift_q, tx_shift_d;
  logic [7:0] rx_shift_q, rx_shift_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic       sck_q, sck_d;
  logic       ssel_q, ssel_d;
  logic       mosi_q, mosi_d;
  logic       miso_meta_q, miso_sync_q;
  logic       phase_done;

`ifdef SPI_BURST_EN
  logic       last_q, last_d;
`else
  logic       unused_tx_last;
  assign unused_tx_last = tx_last;
`endif

  assign phase_done = (div_q == 8'd0);

  always_comb begin
    state_d    = state_q;
    div_d      = phase_done ? div_q : div_q - 8'd1;
    bit_d      = bit_q;
    tx_shift_d = tx_shift_q;
    rx_shift_d = rx_shift_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
`ifdef SPI_BURST_EN
    last_d     = last_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (tx_valid) begin
          tx_shift_d = tx_data;
`ifdef SPI_BURST_EN
          last_d     = tx_last;
`endif
          state_d    = StLead;
        end
      end
      StLead: begin
        if (phase_done) begin
          bit_d   = 3'd7;
          state_d = StHigh;
        end
      end
      StHigh: begin
        if (phase_done) begin
          rx_shift_d = {rx_shift_q[6:0], miso_sync_q};
          if (bit_q == 3'd0) begin
            state_d = StTail;
          end else begin
            bit_d      = bit_q - 3'd1;
            tx_shift_d = {tx_shift_q[6:0], 1'b0};
            state_d    = StLow;
          end
        end
      end
      StLow: begin
        if (phase_done) state_d = StHigh;
      end
      StTail: begin
        if (phase_done) begin
          rx_data_d  = rx_shift_q;
          rx_valid_d = 1'b1;
`ifdef SPI_BURST_EN
          state_d    = last_q ? StGap : StWait;
`else
          state_d    = StGap;
`endif
        end
      end
      StGap: begin
        if (phase_done) state_d = StIdle;
      end
`ifdef SPI_BURST_EN
      // Next byte reuses the lead phase as its bit-7 setup time.
      StWait: begin
        if (tx_valid) begin
          tx_shift_d = tx_data;
          last_d     = tx_last;
          state_d    = StLead;
        end
      end
`endif
      default: state_d = StIdle;
    endcase

    if (state_d != state_q) div_d = (state_d == StGap) ? GapLoad : HalfLoad;

    // Pins are registered from the next state so they switch with the state register.
    sck_d  = (state_d == StHigh);
    ssel_d = (state_d == StIdle) || (state_d == StGap);
    mosi_d = ((state_d == StLead) || (state_d == StHigh) || (state_d == StLow)) ?
             tx_shift_d[7] : 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      div_q       <= 8'd0;
      bit_q       <= 3'd0;
      tx_shift_q  <= 8'd0;
      rx_shift_q  <= 8'd0;
      rx_data_q   <= 8'd0;
      rx_valid_q  <= 1'b0;
      sck_q       <= 1'b0;
      ssel_q      <= 1'b1;
      mosi_q      <= 1'b0;
      miso_meta_q <= 1'b0;
      miso_sync_q <= 1'b0;
`ifdef SPI_BURST_EN
      last_q      <= 1'b1;
`endif
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      bit_q       <= bit_d;
      tx_shift_q  <= tx_shift_d;
      rx_shift_q  <= rx_shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      sck_q       <= sck_d;
      ssel_q      <= ssel_d;
      mosi_q      <= mosi_d;
      miso_meta_q <= MISO;
      miso_sync_q <= miso_meta_q;
`ifdef SPI_BURST_EN
      last_q      <= last_d;
`endif
    end
  end

`ifdef SPI_BURST_EN
  assign tx_ready = (state_q == StIdle) || (state_q == StWait);
`else
  assign tx_ready = (state_q == StIdle);
`endif
  assign busy     = (state_q != StIdle);
  assign rx_valid = rx_valid_q;
  assign rx_data  = rx_data_q;
  assign SCK      = sck_q;
  assign SSEL     = ssel_q;
  assign MOSI     = mosi_q;

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master with a clk-sampled SPI slave model (echo / preload / stuck-high).
`timescale 1ns/1ps
module tb_spi_master;

  localparam int unsigned Half = 8;
  localparam int unsigned Gap  = 16;
  localparam int unsigned Frame = 17 * Half;

  logic       clk = 1'b0;
  logic       rst;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_last;
  logic       tx_ready;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       busy;
  logic       SCK;
  logic       MOSI;
  logic       MISO;
  logic       SSEL;

  spi_master #(.HALF_DIV(Half), .GAP_DIV(Gap)) dut (
    .clk      (clk),
    .rst      (rst),
    .tx_valid (tx_valid),
    .tx_data  (tx_data),
    .tx_last  (tx_last),
    .tx_ready (tx_ready),
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .busy     (busy),
    .SCK      (SCK),
    .MOSI     (MOSI),
    .MISO     (MISO),
    .SSEL     (SSEL)
  );

  always #5 clk = ~clk;

  // Slave model: samples MOSI after SCK rises, shifts after SCK falls, MSB drives MISO.
  logic       load_en = 1'b1;
  logic [7:0] load_val = 8'h00;
  logic       force_one = 1'b0;
  logic [7:0] sreg = 8'h00;
  logic       sck_p = 1'b0;
  logic       ssel_p = 1'b1;
  logic       mosi_s = 1'b0;

  always @(posedge clk) begin
    sck_p  <= SCK;
    ssel_p <= SSEL;
    if (!SSEL && ssel_p && load_en) sreg <= load_val;
    else if (SCK && !sck_p) mosi_s <= MOSI;
    else if (!SCK && sck_p && !SSEL) sreg <= {sreg[6:0], mosi_s};
  end
  assign MISO = force_one ? 1'b1 : sreg[7];

  // Passive monitors.
  int         edges = 0;
  logic [7:0] cap = 8'h00;
  int         rxv_cnt = 0;
  logic [7:0] last_rx = 8'h00;
  int         ssel_low = 0;
  int         ssel_rise = 0;

  always @(posedge SCK) begin
    edges <= edges + 1;
    cap   <= {cap[6:0], MOSI};
  end
  always @(negedge clk) begin
    if (rx_valid) begin
      rxv_cnt <= rxv_cnt + 1;
      last_rx <= rx_data;
    end
    if (!SSEL) ssel_low <= ssel_low + 1;
  end
  always @(posedge SSEL) ssel_rise <= ssel_rise + 1;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    vectors++;
    assert (obs === want) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting posedge.
  task automatic send(input logic [7:0] d, input logic l);
    int n;
    n = 0;
    tx_data  = d;
    tx_last  = l;
    tx_valid = 1'b1;
    while (!tx_ready && n < 4000) begin
      @(negedge clk);
      n++;
    end
    chk("accept_timeout", 32'(n >= 4000), 32'd0);
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic wait_rx(input int prev);
    int n;
    n = 0;
    while (rxv_cnt == prev && n < 4000) begin
      @(negedge clk);
      n++;
    end
    chk("rx_timeout", 32'(n >= 4000), 32'd0);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 4000) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", 32'(n >= 4000), 32'd0);
  endtask

  int         r0, e0, s0, q0, rl, sh, n;
  logic [7:0] first_rx;

  initial begin
    rst      = 1'b1;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    tx_last  = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_sck", 32'(SCK), 32'd0);
    chk("rst_ssel", 32'(SSEL), 32'd1);
    chk("rst_mosi", 32'(MOSI), 32'd0);
    chk("rst_tx_ready", 32'(tx_ready), 32'd1);
    chk("rst_rx_valid", 32'(rx_valid), 32'd0);
    chk("rst_rx_data", 32'(rx_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // 0xA5 into a slave preloaded with zero.
    load_en = 1'b1; load_val = 8'h00;
    r0 = rxv_cnt; e0 = edges; s0 = ssel_low;
    send(8'hA5, 1'b1);
    chk("a5_busy", 32'(busy), 32'd1);
    wait_rx(r0);
    wait_idle();
    chk("a5_edges", 32'(edges - e0), 32'd8);
    chk("a5_mosi_bits", 32'(cap), 32'hA5);
    chk("a5_rx_data", 32'(last_rx), 32'h00);
    chk("a5_rx_pulses", 32'(rxv_cnt - r0), 32'd1);
    chk("a5_ssel_low", 32'(ssel_low - s0), 32'(Frame));

    // Echo: slave returns the previous byte.
    load_en = 1'b0;
    r0 = rxv_cnt;
    send(8'h5C, 1'b1);
    wait_rx(r0);
    wait_idle();
    chk("echo_rx", 32'(last_rx), 32'hA5);
    chk("echo_mosi", 32'(cap), 32'h5C);

    // MISO stuck high.
    force_one = 1'b1;
    r0 = rxv_cnt;
    send(8'h00, 1'b1);
    wait_rx(r0);
    wait_idle();
    chk("miso_one_rx", 32'(last_rx), 32'hFF);
    force_one = 1'b0;

    // Slave shifts out 0x3C.
    load_en = 1'b1; load_val = 8'h3C;
    r0 = rxv_cnt;
    send(8'hE7, 1'b1);
    wait_rx(r0);
    wait_idle();
    chk("miso_3c_rx", 32'(last_rx), 32'h3C);

    // Back-to-back with tx_valid held.
    load_val = 8'h96;
    r0 = rxv_cnt;
    send(8'h01, 1'b1);
    tx_valid = 1'b1;
    tx_data  = 8'h02;
    rl = 0; sh = 0; n = 0; first_rx = 8'h00;
    while (!tx_ready && n < 4000) begin
      if (SSEL) sh++;
      if (rx_valid) first_rx = rx_data;
      rl++;
      n++;
      @(negedge clk);
    end
    if (SSEL) sh++;
    chk("b2b_ready_low", 32'(rl), 32'(Frame + Gap));
    chk("b2b_ssel_high", 32'(sh), 32'(Gap + 1));
    chk("b2b_first_rx", 32'(first_rx), 32'h96);
    @(negedge clk);
    tx_valid = 1'b0;
    wait_rx(r0 + 1);
    wait_idle();
    chk("b2b_second_rx", 32'(last_rx), 32'h96);
    chk("b2b_second_mosi", 32'(cap), 32'h02);

`ifdef SPI_BURST_EN
    load_en = 1'b1; load_val = 8'h00;
    r0 = rxv_cnt; e0 = edges; q0 = ssel_rise;
    send(8'hA5, 1'b0);
    wait_rx(r0);
    chk("burst_rx0", 32'(last_rx), 32'h00);
    chk("burst_wait_ready", 32'(tx_ready), 32'd1);
    chk("burst_wait_ssel", 32'(SSEL), 32'd0);
    send(8'h3C, 1'b1);
    wait_rx(r0 + 1);
    chk("burst_rx1", 32'(last_rx), 32'hA5);
    chk("burst_no_rise", 32'(ssel_rise - q0), 32'd0);
    wait_idle();
    chk("burst_one_rise", 32'(ssel_rise - q0), 32'd1);
    chk("burst_edges", 32'(edges - e0), 32'd16);
    chk("burst_mosi", 32'(cap), 32'h3C);
`else
    load_en = 1'b1; load_val = 8'h11;
    r0 = rxv_cnt; q0 = ssel_rise;
    send(8'hC3, 1'b0);
    wait_rx(r0);
    wait_idle();
    chk("nolast_rx", 32'(last_rx), 32'h11);
    chk("nolast_rise", 32'(ssel_rise - q0), 32'd1);
    chk("nolast_ready", 32'(tx_ready), 32'd1);
`endif

    // Abort at bit 4, then a clean 0x81.
    load_val = 8'h00;
    r0 = rxv_cnt; e0 = edges;
    send(8'hF0, 1'b1);
    n = 0;
    while (edges < e0 + 4 && n < 4000) begin
      @(negedge clk);
      n++;
    end
    chk("abort_timeout", 32'(n >= 4000), 32'd0);
    rst = 1'b1;
    #1;
    chk("abort_ssel", 32'(SSEL), 32'd1);
    chk("abort_sck", 32'(SCK), 32'd0);
    chk("abort_rx_valid", 32'(rx_valid), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("abort_no_rx", 32'(rxv_cnt - r0), 32'd0);
    load_val = 8'h5A;
    r0 = rxv_cnt; e0 = edges;
    send(8'h81, 1'b1);
    wait_rx(r0);
    wait_idle();
    chk("post_abort_rx", 32'(last_rx), 32'h5A);
    chk("post_abort_mosi", 32'(cap), 32'h81);
    chk("post_abort_edges", 32'(edges - e0), 32'd8);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
